// File: rtl/mux_pkg.sv
// Shared constants for the round-robin / manual-select data multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 6;

  // Channel-index width, never narrower than one bit.
  function automatic int sel_width(input int channels);
    return ($clog2(channels) < 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Input-channel and result handshake bundle for rr_mux.
interface rr_mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       d_valid;
  logic [CHANNELS-1:0]       d_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          res;
  logic [SEL_W-1:0]          res_sel;
  logic                      res_valid;
  logic                      res_ready;

  modport master (
    output d, d_valid, mode, sel, res_ready,
    input  d_ready, res, res_sel, res_valid
  );

  modport slave (
    input  d, d_valid, mode, sel, res_ready,
    output d_ready, res, res_sel, res_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid channel after i_ptr, wrapping.
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_valid,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic                o_grant_any,
  output logic [SEL_W-1:0]    o_grant_idx
);

  int w_idx;

  // Scan farthest-first so the nearest valid channel after i_ptr wins;
  // k = CHANNELS revisits i_ptr itself, covering the single-requester case.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_grant_any = 1'b0;
    o_grant_idx = '0;
    w_idx       = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % CHANNELS;
      if (i_valid[w_idx]) begin
        o_grant_any = 1'b1;
        o_grant_idx = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel data multiplexer with manual or round-robin selection and a
// single registered output slot with valid/ready flow control.
module rr_mux
  import mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic    clk,
  input  logic    rst_n,
  rr_mux_if.slave bus
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam int VEXT  = 1 << SEL_W;

  logic [WIDTH-1:0]    r_res;
  logic [SEL_W-1:0]    r_res_sel;
  logic                r_res_valid;
  logic [SEL_W-1:0]    r_ptr;

  logic [VEXT-1:0]     w_valid_ext;
  logic                w_man_any;
  logic                w_rr_any;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_rr_mode;
  logic                w_grant_any;
  logic [SEL_W-1:0]    w_grant_idx;
  logic                w_load;
  logic [WIDTH-1:0]    w_data;
  logic [CHANNELS-1:0] w_ready;

  // Zero-extend so out-of-range manual selects read as "not valid".
  assign w_valid_ext = VEXT'(bus.d_valid);
  assign w_man_any   = (int'(bus.sel) < CHANNELS) && w_valid_ext[bus.sel];
  assign w_rr_mode   = (mode_e'(bus.mode) == MODE_RR);

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .i_valid     (bus.d_valid),
    .i_ptr       (r_ptr),
    .o_grant_any (w_rr_any),
    .o_grant_idx (w_rr_idx)
  );

  assign w_grant_any = w_rr_mode ? w_rr_any : w_man_any;
  assign w_grant_idx = w_rr_mode ? w_rr_idx : bus.sel;
  // rst_n gating keeps d_ready quiet while reset is held.
  assign w_load      = rst_n & w_grant_any & (~r_res_valid | bus.res_ready);

  always_comb begin
    w_data  = '0;
    w_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_data     = bus.d[i*WIDTH +: WIDTH];
        w_ready[i] = w_load;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_res_sel   <= '0;
      r_res_valid <= 1'b0;
      r_ptr       <= SEL_W'(CHANNELS - 1);
    end else if (w_load) begin
      r_res       <= w_data;
      r_res_sel   <= w_grant_idx;
      r_res_valid <= 1'b1;
      r_ptr       <= w_grant_idx;
    end else if (r_res_valid && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.d_ready   = w_ready;
  assign bus.res       = r_res;
  assign bus.res_sel   = r_res_sel;
  assign bus.res_valid = r_res_valid;

endmodule

// File: tb/tb_rr_mux.sv
// Randomised and directed checks of rr_mux against a behavioural model.
module tb_rr_mux;

  localparam int W  = 8;
  localparam int CH = 6;

  logic clk;
  logic rst_n;

  rr_mux_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  rr_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] dv [CH];

  // Reference state
  int        m_ptr;
  bit        m_valid;
  int        m_sel;
  logic [W-1:0] m_res;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic apply_data();
    for (int i = 0; i < CH; i++) bus.d[i*W +: W] = dv[i];
  endtask

  task automatic model_reset();
    m_ptr   = CH - 1;
    m_valid = 0;
    m_sel   = 0;
    m_res   = '0;
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // combinational accept strobe, advances one cycle, checks the registers.
  task automatic step(input string tag);
    bit any;
    int g;
    bit load;
    logic [CH-1:0] exp_ready;
    any = 0;
    g   = 0;
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < CH) begin
        if (bus.d_valid[bus.sel]) begin
          any = 1;
          g   = int'(bus.sel);
        end
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (!any && bus.d_valid[c]) begin
          any = 1;
          g   = c;
        end
      end
    end
    load      = any && (!m_valid || bus.res_ready);
    exp_ready = load ? CH'(1 << g) : '0;
    #1;
    check({tag, ".d_ready"}, 64'(bus.d_ready), 64'(exp_ready));
    @(posedge clk);
    if (load) begin
      m_res   = dv[g];
      m_sel   = g;
      m_valid = 1;
      m_ptr   = g;
    end else if (m_valid && bus.res_ready) begin
      m_valid = 0;
    end
    #1;
    check({tag, ".res_valid"}, 64'(bus.res_valid), 64'(m_valid));
    check({tag, ".res_sel"},   64'(bus.res_sel),   64'(m_sel));
    check({tag, ".res"},       64'(bus.res),       64'(m_res));
    @(negedge clk);
  endtask

  int exp_seq [5] = '{0, 2, 3, 5, 0};

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.d_valid   = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < CH; i++) dv[i] = W'((i + 1) * 10);
    apply_data();
    model_reset();

    #2;
    check("reset.res",       64'(bus.res),       64'd0);
    check("reset.res_sel",   64'(bus.res_sel),   64'd0);
    check("reset.res_valid", 64'(bus.res_valid), 64'd0);
    check("reset.d_ready",   64'(bus.d_ready),   64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select stepping through every channel
    bus.d_valid   = '1;
    bus.res_ready = 1'b1;
    for (int s = 0; s < CH; s++) begin
      bus.sel = 3'(s);
      step("manual");
      check("manual.value", 64'(bus.res), 64'((s + 1) * 10));
    end

    // Out-of-range selects never grant; the held word drains
    bus.sel = 3'd6;
    step("sel6");
    bus.sel = 3'd7;
    step("sel7");
    check("sel7.drained", 64'(bus.res_valid), 64'd0);

    // Round-robin over a sparse valid pattern
    bus.mode    = 1'b1;
    bus.d_valid = 6'b101101;
    for (int n = 0; n < 5; n++) begin
      step("rr_sparse");
      check("rr_sparse.seq", 64'(bus.res_sel), 64'(exp_seq[n]));
    end

    // Backpressure holds the slot and blocks all accepts
    bus.d_valid   = '1;
    bus.res_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step("stall");
      check("stall.hold", 64'(bus.res), 64'd10);
    end
    bus.res_ready = 1'b1;
    step("release");
    check("release.next", 64'(bus.res_sel), 64'd1);

    // Single requester granted repeatedly, including when it equals ptr
    bus.d_valid = 6'b010000;
    for (int n = 0; n < 3; n++) begin
      step("single");
      check("single.sel", 64'(bus.res_sel), 64'd4);
    end

    // Data and mode change take effect in the same cycle
    dv[2] = 8'd33;
    apply_data();
    bus.mode    = 1'b0;
    bus.sel     = 3'd2;
    bus.d_valid = 6'b000100;
    step("newdata");
    check("newdata.res", 64'(bus.res), 64'd33);

    // Asynchronous reset mid-stream discards the held word
    bus.mode    = 1'b1;
    bus.d_valid = '1;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.res",       64'(bus.res),       64'd0);
    check("midrst.res_sel",   64'(bus.res_sel),   64'd0);
    check("midrst.res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst.d_ready",   64'(bus.d_ready),   64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst.first", 64'(bus.res_sel), 64'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < CH; i++) dv[i] = W'($urandom);
        apply_data();
      end
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = 3'($urandom_range(0, 7));
      bus.d_valid   = CH'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal 1..64).
REQ-002 SHALL have parameter CHANNELS, default 6, meaning number of input channels (legal 2..16).
REQ-003 SHALL have localparam SEL_W = max(1, clog2(CHANNELS)), meaning the channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port d, input, CHANNELS*WIDTH bits: channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port d_valid, input, CHANNELS bits: per-channel data-valid.
REQ-008 SHALL have port d_ready, output, CHANNELS bits: per-channel accept strobe (combinational).
REQ-009 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = round-robin.
REQ-010 SHALL have port sel, input, SEL_W bits: channel index used in manual mode.
REQ-011 SHALL have port res, output, WIDTH bits: registered selected data.
REQ-012 SHALL have port res_sel, output, SEL_W bits: index of the channel that produced res.
REQ-013 SHALL have port res_valid, output, 1 bit: res holds an unconsumed word.
REQ-014 SHALL have port res_ready, input, 1 bit: downstream accepts res this cycle.

Function
REQ-015 Load condition SHALL be: load = grant_any & (~res_valid | res_ready).
REQ-016 In manual mode, grant SHALL be to channel sel when sel < CHANNELS and d_valid[sel]; otherwise there SHALL be no grant.
REQ-017 In round-robin mode, grant SHALL go to the first valid channel found searching from ptr+1 upward and wrapping modulo CHANNELS, where ptr is the last granted channel.
REQ-018 d_ready[i] SHALL be 1 only when load = 1 and i is the granted channel; at most one bit of d_ready SHALL be high per cycle.
REQ-019 On load, res, res_sel and res_valid SHALL take the granted channel's data, its index, and 1 respectively at the next edge; latency SHALL be 1 cycle.
REQ-020 If res_valid & res_ready & ~grant_any, res_valid SHALL clear; res and res_sel SHALL hold their values.
REQ-021 If res_valid & ~res_ready, res, res_sel and res_valid SHALL hold and d_ready SHALL be all zero (no loss, no overwrite).
REQ-022 Throughput SHALL be one word per cycle while res_ready = 1 and a grant exists.
REQ-023 ptr SHALL update to the granted index on every load in either mode; it SHALL not change otherwise.
REQ-024 A mode or sel change SHALL take effect in the same cycle (combinational grant); no handshake in flight SHALL be dropped.
REQ-025 A single valid channel in round-robin mode SHALL be granted on every load, including when it equals ptr (wrap case).

Reset
REQ-026 While rst_n = 0 (asynchronous assertion), res SHALL be 0, res_sel 0, res_valid 0 and ptr CHANNELS-1, so the first round-robin grant is channel 0.
REQ-027 d_ready SHALL be all zero while rst_n = 0; on reset mid-transfer the pending word SHALL be discarded.
REQ-028 Reset deassertion SHALL take effect at the first clk rising edge after rst_n = 1.

Structure
REQ-029 Shared package mux_pkg SHALL hold MODE_MANUAL = 0, MODE_RR = 1, and the default WIDTH/CHANNELS constants.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: valid vector, ptr; outputs: grant_any, grant index); state SHALL stay in rr_mux.

Verification (WIDTH = 8, CHANNELS = 6, d0..d5 = 10, 20, 30, 40, 50, 60)
REQ-031 Manual mode, all valid, res_ready = 1, sel stepping 0..5 each cycle -> res 10, 20, 30, 40, 50, 60, each one cycle after the corresponding sel.
REQ-032 Manual mode, sel = 6 and sel = 7 -> d_ready = 0; res_valid clears after draining.
REQ-033 Round-robin mode, d_valid = 6'b101101, res_ready = 1 -> res_sel sequence 0, 2, 3, 5, 0; res sequence 10, 30, 40, 60, 10.
REQ-034 Round-robin mode, res_ready held 0 for 3 cycles -> res = 10 holds, d_ready = 0; on release, next res_sel = 1.
REQ-035 Round-robin mode, only channel 4 valid -> res_sel = 4 on consecutive cycles; d2 changed from 30 to 33 at cycle 5 with mode = 0 and sel = 2 -> res = 33 on cycle 6.
REQ-036 rst_n pulsed low mid-stream -> res, res_sel and res_valid are 0 immediately; the first grant after release is channel 0.
